traffic_light_ctrl: RTL

Sequencer for a two-way intersection (north-south / east-west) with an optional pedestrian phase. An internal tick generator divides the 50 MHz board clock into a one-cycle enable pulse. A Moore state machine advances through the light phases, with each phase lasting a parameterised number of ticks. The block sits between the board clock/reset and the LED outputs of the traffic-light top level and replaces free-running divided clocks with a single-clock-domain design.

---
 rtl/tlc_pkg.sv | 34 +++
 rtl/tick_gen.sv | 35 +++
 rtl/traffic_light_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared state encodings and light constants for traffic_light_ctrl
package tlc_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_1 = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_2 = 3'd5,
        PED_WALK  = 3'd6
    } tlc_state_e;

    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

    function automatic logic [2:0] ns_light_of(input tlc_state_e s);
        case (s)
            NS_GREEN:  return LIGHT_GRN;
            NS_YELLOW: return LIGHT_YEL;
            default:   return LIGHT_RED;
        endcase
    endfunction

    function automatic logic [2:0] ew_light_of(input tlc_state_e s);
        case (s)
            EW_GREEN:  return LIGHT_GRN;
            EW_YELLOW: return LIGHT_YEL;
            default:   return LIGHT_RED;
        endcase
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - divides clk by CLK_FREQ/TICK_HZ into a one-cycle tick, frozen while enable is low
module tick_gen #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int TICK_HZ  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = enable && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - two-way intersection sequencer; pedestrian phase built only with TLC_PED_EN
module traffic_light_ctrl
    import tlc_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int TICK_HZ  = 1,
    parameter int T_GREEN  = 10,
    parameter int T_YELLOW = 3,
    parameter int T_ALLRED = 1,
    parameter int T_PED    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       ped_walk,
    output logic [2:0] phase,
    output logic       tick
);

    localparam int T_MAX = (T_GREEN > T_YELLOW ? T_GREEN : T_YELLOW) >
                           (T_ALLRED > T_PED ? T_ALLRED : T_PED) ?
                           (T_GREEN > T_YELLOW ? T_GREEN : T_YELLOW) :
                           (T_ALLRED > T_PED ? T_ALLRED : T_PED);
    localparam int TW = $clog2(T_MAX) + 1;

    tlc_state_e     state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [2:0]     ns_q, ew_q;

    // Timer holds ticks remaining minus one, so a state lasts exactly T_x ticks.
    function automatic logic [TW-1:0] load_of(input tlc_state_e s);
        case (s)
            NS_GREEN, EW_GREEN:   return TW'(T_GREEN - 1);
            NS_YELLOW, EW_YELLOW: return TW'(T_YELLOW - 1);
            ALL_RED_1, ALL_RED_2: return TW'(T_ALLRED - 1);
            PED_WALK:             return TW'(T_PED - 1);
            default:              return '0;
        endcase
    endfunction

    tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .TICK_HZ  (TICK_HZ)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick)
    );

`ifdef TLC_PED_EN
    logic pend_q, pend_d, walk_q;
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
`endif

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
`ifdef TLC_PED_EN
        pend_d  = pend_q;
        if (ped_req && state_q != PED_WALK) begin
            pend_d = 1'b1;
        end
`endif
        if (tick) begin
            if (timer_q == '0) begin
                case (state_q)
                    NS_GREEN:  state_d = NS_YELLOW;
                    NS_YELLOW: state_d = ALL_RED_1;
                    ALL_RED_1: state_d = EW_GREEN;
                    EW_GREEN:  state_d = EW_YELLOW;
                    EW_YELLOW: state_d = ALL_RED_2;
`ifdef TLC_PED_EN
                    // A request arriving on the exit cycle itself still earns the walk.
                    ALL_RED_2: state_d = (pend_q || ped_req) ? PED_WALK : NS_GREEN;
`else
                    ALL_RED_2: state_d = NS_GREEN;
`endif
                    default:   state_d = NS_GREEN;
                endcase
                timer_d = load_of(state_d);
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end
`ifdef TLC_PED_EN
        if (state_d == PED_WALK && state_q != PED_WALK) begin
            pend_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ALL_RED_2;
            timer_q <= '0;
            ns_q    <= LIGHT_RED;
            ew_q    <= LIGHT_RED;
`ifdef TLC_PED_EN
            pend_q  <= 1'b0;
            walk_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ns_q    <= ns_light_of(state_d);
            ew_q    <= ew_light_of(state_d);
`ifdef TLC_PED_EN
            pend_q  <= pend_d;
            walk_q  <= (state_d == PED_WALK);
`endif
        end
    end

    assign ns_light = ns_q;
    assign ew_light = ew_q;
    assign phase    = state_q;
`ifdef TLC_PED_EN
    assign ped_walk = walk_q;
`else
    assign ped_walk = 1'b0;
`endif

endmodule
